// File: rtl/sobol_seq_gen_pkg.sv
// Shared state encoding, default sizes and bit helpers for the Sobol sequence engine.
package sobol_seq_gen_pkg;

  localparam int SOBOL_WIDTH = 32;
  localparam int SOBOL_M     = 50;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} sobol_state_e;

  // Index of the lowest zero bit among the low w bits, i.e. the trailing-ones count.
  function automatic int trailing_ones(input logic [63:0] v, input int w);
    int c;
    c = 0;
    for (int i = 63; i >= 0; i--) begin
      if (i < w && !v[i]) c = i;
    end
    return c;
  endfunction

endpackage

// File: rtl/sobol_seq_gen_skid_buf.sv
// Two-entry ready/valid buffer; the producer watches count and never pushes into a full
// buffer, so in_valid carries no ready handshake of its own.
module sobol_seq_gen_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push, pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign count     = cnt_q;

  always_comb begin
    pop   = out_valid & out_ready;
    push  = in_valid & ((cnt_q != 2'd2) | pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_data;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sobol_seq_gen.sv
// Gray-code Sobol engine: one direction-word lookup and one XOR per emitted point.
// Build option SOBOL_SKIP_ZERO_EN starts the sequence at index 1 instead of 0.
module sobol_seq_gen
  import sobol_seq_gen_pkg::*;
#(
  parameter int WIDTH = SOBOL_WIDTH,
  parameter int M     = SOBOL_M
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     n_paths,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     sobol_out,
  output logic [$clog2(M)-1:0] dim_out,
  output logic [WIDTH-1:0]     path_out,
  output logic                 last_out
);

  localparam int DIMW   = $clog2(M);
  localparam int DATA_W = 2 * WIDTH + DIMW + 1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [DIMW-1:0]  D_MAX = DIMW'(M - 1);
`ifdef SOBOL_SKIP_ZERO_EN
  localparam logic [WIDTH-1:0] FIRST    = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAST_OFS = '0;
`else
  localparam logic [WIDTH-1:0] FIRST    = '0;
  localparam logic [WIDTH-1:0] LAST_OFS = WIDTH'(1);
`endif

  if (M < 2) begin : g_bad_m
    $error("sobol_seq_gen: M must be at least 2");
  end

  // Direction table stand-in: bit k leads at WIDTH-1-k, lower bits vary per dimension.
  function automatic logic [WIDTH-1:0] dir_word(input int d, input int k);
    logic [WIDTH-1:0] base;
    base = ONE << (WIDTH - 1 - k);
    if (d == 0) return base;
    return base | (base >> ((d % (WIDTH - 1)) + 1));
  endfunction

  sobol_state_e     st_q, st_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] n_q, n_d, n_last_q, n_last_d, n_m1;
  logic [DIMW-1:0]  d_q, d_d, clr_q, clr_d;
  logic             s1_valid_q, s1_valid_d, s1_zero_q, s1_zero_d, s1_last_q, s1_last_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d, s1_v_q, s1_v_d, s1_path_q, s1_path_d;
  logic [DIMW-1:0]  s1_dim_q, s1_dim_d;
  logic [WIDTH-1:0] x_ram [M];
  logic [WIDTH-1:0] nxt;
  logic [2:0]       occ;
  logic [1:0]       skid_cnt;
  logic             issue, issue_last, pop, skid_valid;
  logic [DATA_W-1:0] skid_out;

  always_comb begin
    pop        = skid_valid & out_ready;
    occ        = {1'b0, skid_cnt} + {2'b0, s1_valid_q} - {2'b0, pop};
    issue      = (st_q == RUN) && (occ < 3'd2);
    issue_last = (n_q == n_last_q) && (d_q == D_MAX);
    n_m1       = n_q - ONE;
    nxt        = s1_zero_q ? '0 : (s1_x_q ^ s1_v_q);

    s1_valid_d = issue;
    s1_x_d     = x_ram[d_q];
    s1_v_d     = dir_word(int'(d_q), trailing_ones(64'(n_m1), WIDTH));
    s1_dim_d   = d_q;
    s1_path_d  = n_q;
    s1_last_d  = issue_last;
    s1_zero_d  = (n_q == '0);

    st_d     = st_q;
    busy_d   = busy_q;
    done_d   = done_q;
    n_d      = n_q;
    n_last_d = n_last_q;
    d_d      = d_q;
    clr_d    = clr_q;

    case (st_q)
      IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          n_d      = FIRST;
          n_last_d = n_paths - LAST_OFS;
          d_d      = '0;
          clr_d    = '0;
          if (n_paths == '0) begin
            st_d   = DONE;
            done_d = 1'b1;
          end else begin
            st_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        clr_d = clr_q + DIMW'(1);
        if (clr_q == D_MAX) st_d = RUN;
      end
      RUN: begin
        if (issue) begin
          if (issue_last) begin
            st_d = DRAIN;
          end else if (d_q == D_MAX) begin
            d_d = '0;
            n_d = n_q + ONE;
          end else begin
            d_d = d_q + DIMW'(1);
          end
        end
      end
      DRAIN: begin
        if (!s1_valid_q && skid_cnt == 2'd0) begin
          st_d   = DONE;
          done_d = 1'b1;
        end
      end
      DONE: begin
        st_d   = IDLE;
        done_d = 1'b0;
        busy_d = 1'b0;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      n_q        <= '0;
      n_last_q   <= '0;
      d_q        <= '0;
      clr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_v_q     <= '0;
      s1_path_q  <= '0;
      s1_dim_q   <= '0;
    end else begin
      st_q       <= st_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      n_q        <= n_d;
      n_last_q   <= n_last_d;
      d_q        <= d_d;
      clr_q      <= clr_d;
      s1_valid_q <= s1_valid_d;
      s1_zero_q  <= s1_zero_d;
      s1_last_q  <= s1_last_d;
      s1_x_q     <= s1_x_d;
      s1_v_q     <= s1_v_d;
      s1_path_q  <= s1_path_d;
      s1_dim_q   <= s1_dim_d;
    end
  end

  // Same-dimension reads trail writes by M >= 2 issues, so no bypass path exists.
  always_ff @(posedge clk) begin
    if (st_q == CLEAR) x_ram[clr_q] <= '0;
    else if (s1_valid_q) x_ram[s1_dim_q] <= nxt;
  end

  sobol_seq_gen_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_q),
    .in_data   ({nxt, s1_dim_q, s1_path_q, s1_last_q}),
    .out_valid (skid_valid),
    .out_ready (out_ready),
    .out_data  (skid_out),
    .count     (skid_cnt)
  );

  assign out_valid = skid_valid;
  assign {sobol_out, dim_out, path_out, last_out} = skid_out;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sobol_seq_gen.sv
// Scoreboard bench for sobol_seq_gen: stimulus queues expected points, a monitor pops them.
module tb_sobol_seq_gen;

  localparam int W = 32;
  localparam int M = 50;

`ifdef SOBOL_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, out_ready, busy, done, out_valid, last_out;
  logic [W-1:0]  n_paths, sobol_out, path_out;
  logic [5:0]    dim_out;

  sobol_seq_gen #(.WIDTH(W), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_paths   (n_paths),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sobol_out (sobol_out),
    .dim_out   (dim_out),
    .path_out  (path_out),
    .last_out  (last_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] val;
    logic [5:0]  dim;
    logic [31:0] path;
    logic        last;
  } pt_t;

  pt_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  pops = 0;
  int  done_cnt = 0;
  bit  rand_mode = 1'b0;
  bit  mark_seen = 1'b0;
  logic [31:0] hand0 [4];

  function automatic logic [31:0] dir_v(input int d, input int i);
    logic [31:0] b;
    b = 32'h8000_0000 >> i;
    return (d == 0) ? b : (b | (b >> ((d % 31) + 1)));
  endfunction

  // Closed form: x(n) = XOR of direction words selected by the bits of gray(n).
  function automatic logic [31:0] sobol_model(input int d, input logic [31:0] n);
    logic [31:0] g, x;
    g = n ^ (n >> 1);
    x = '0;
    for (int i = 0; i < 32; i++) if (g[i]) x ^= dir_v(d, i);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_run(input int np, input bit use_hand);
    pt_t e;
    for (int p = 0; p < np; p++) begin
      for (int d = 0; d < M; d++) begin
        e.path = 32'(FIRST + p);
        e.dim  = 6'(d);
        e.val  = (use_hand && d == 0) ? hand0[p] : sobol_model(d, e.path);
        e.last = (p == np - 1) && (d == M - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input logic [31:0] np);
    @(posedge clk); #1;
    start   = 1'b1;
    n_paths = np;
    @(posedge clk); #1;
    start   = 1'b0;
    n_paths = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles, required a done pulse", name, budget);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: in-order compare on every accepted point, hold check on every stall.
  initial begin
    pt_t got, held, e;
    bit stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {sobol_out, dim_out, path_out, last_out};
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (stall_prev) begin
          checks++;
          if (!out_valid || got !== held) begin
            errors++;
            $display("FAIL stall_hold: got valid %b data %h, required valid 1 data %h",
                     out_valid, got, held);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          pops++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_point: got path %0d dim %0d val %h, required none",
                     path_out, dim_out, sobol_out);
          end else begin
            e = exp_q.pop_front();
            if (got !== e)
              $display("FAIL point: got path %0d dim %0d val %h last %b, required path %0d dim %0d val %h last %b",
                       got.path, got.dim, got.val, got.last, e.path, e.dim, e.val, e.last);
            if (got !== e) errors++;
          end
          if (path_out == 32'd37 && dim_out == 6'd12) mark_seen = 1'b1;
        end
        stall_prev = out_valid && !out_ready;
        held = got;
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0;
`ifdef SOBOL_SKIP_ZERO_EN
    hand0 = '{32'h8000_0000, 32'hC000_0000, 32'h4000_0000, 32'h6000_0000};
`else
    hand0 = '{32'h0000_0000, 32'h8000_0000, 32'hC000_0000, 32'h4000_0000};
`endif
    rst = 1'b1; start = 1'b0; n_paths = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy_done", 64'({busy, done}), 64'd0);
    check("reset_data", 64'({sobol_out, last_out}), 64'd0);
    check("reset_path", 64'(path_out), 64'd0);
    rst = 1'b0;

    // Four paths, hand-computed dim 0, full throughput.
    d0 = done_cnt; p0 = pops;
    push_run(4, 1'b1);
    do_start(32'd4);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(2000, "t1");
    repeat (5) @(posedge clk); #1;
    check("t1_points", 64'(pops - p0), 64'(4 * M));
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero paths: one busy cycle with done, no points.
    d0 = done_cnt; p0 = pops;
    do_start(32'd0);
    check("t4_busy_first", 64'(busy), 64'd1);
    check("t4_done_first", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("t4_busy_second", 64'({busy, done}), 64'd0);
    repeat (10) @(posedge clk); #1;
    check("t4_points", 64'(pops - p0), 64'd0);
    check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);

    // 5000 points under random backpressure.
    rand_mode = 1'b1;
    p0 = pops;
    push_run(100, 1'b0);
    do_start(32'd100);
    wait_done(40000, "t3");
    rand_mode = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("t3_points", 64'(pops - p0), 64'd5000);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort with reset mid-run, then a clean short run from a freshly cleared state.
    mark_seen = 1'b0;
    push_run(60, 1'b0);
    do_start(32'd60);
    for (int i = 0; i < 6000 && !mark_seen; i++) @(posedge clk);
    check("t5_reached_mark", 64'(mark_seen), 64'd1);
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("t5_reset_valid", 64'(out_valid), 64'd0);
    check("t5_reset_busy", 64'(busy), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("t5_no_done_on_abort", 64'(done_cnt - d0), 64'd0);
    p0 = pops;
    push_run(2, 1'b0);
    do_start(32'd2);
    wait_done(2000, "t5");
    repeat (5) @(posedge clk); #1;
    check("t5_points", 64'(pops - p0), 64'(2 * M));
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start during RUN with another count must be ignored.
    d0 = done_cnt; p0 = pops;
    push_run(3, 1'b0);
    do_start(32'd3);
    repeat (M + 20) @(posedge clk);
    do_start(32'd7);
    wait_done(3000, "t6");
    repeat (30) @(posedge clk); #1;
    check("t6_points", 64'(pops - p0), 64'(3 * M));
    check("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t6_idle", 64'({busy, out_valid}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
